// File: rtl/multipack_assembler.sv
// Packs consecutive 3-bit {a,b,c} records into a COUNT-lane word.
// The finished word, its per-lane active mask and its fill count go downstream through a valid/ready handshake.
module multipack_assembler #(
  parameter int COUNT = 4,
  localparam int CW = $clog2(COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_rec,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*COUNT-1:0]   out_word,
  output logic [COUNT-1:0]     out_active,
  output logic [CW-1:0]        out_count,
  output logic                 state_dbg
);

  localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q;
  logic [3*COUNT-1:0] word_q;
  logic [CW-1:0]      count_q;
  logic               accept;
  logic               word_done;
  logic               consume;

  // Handshakes: a transfer happens on a clock edge where valid && ready are
  // both high. in_ready is high only in FILL and out_valid only in HOLD.
  // Both decode the state register alone, so neither waits on the other side's valid/ready.
  assign accept    = in_valid && (state_q == FILL);
  assign word_done = accept && ((idx_q == IW'(COUNT - 1)) || in_last);
  assign consume   = out_ready && (state_q == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (word_done) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (consume) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= '0;
      word_q  <= '0;
      count_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < COUNT; i++) begin
        if (idx_q == IW'(i)) word_q[3*i +: 3] <= in_rec;
      end
      if (word_done) begin
        count_q <= CW'(idx_q) + CW'(1);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end else if (consume) begin
      idx_q   <= '0;
      word_q  <= '0;
      count_q <= '0;
    end
  end

  // Unwritten lanes are held at zero, so the raw decode is already masked by "filled".
  always_comb begin
    out_active = '0;
    for (int i = 0; i < COUNT; i++) begin
      out_active[i] = |word_q[3*i +: 2];
    end
  end

  assign out_word  = word_q;
  assign out_count = count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multipack_assembler.sv
// Bench for multipack_assembler: a COUNT=4 instance and a COUNT=1 instance.
// A reference packer builds the expected words into queues that monitors drain as words are consumed.
module tb_multipack_assembler;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   cyc;

  // COUNT=4 instance
  logic        in_valid, in_ready, in_last, out_valid, out_ready, state_dbg;
  logic [2:0]  in_rec;
  logic [11:0] out_word;
  logic [3:0]  out_active;
  logic [2:0]  out_count;

  // COUNT=1 instance
  logic        in_valid1, in_ready1, in_last1, out_valid1, out_ready1, state_dbg1;
  logic [2:0]  in_rec1;
  logic [2:0]  out_word1;
  logic [0:0]  out_active1;
  logic [0:0]  out_count1;

  logic [18:0] exp_q[$];
  logic [4:0]  exp1_q[$];
  logic [18:0] last_exp;

  logic [11:0] m_word;
  logic [3:0]  m_act;
  int          m_cnt;

  int v1_t[2];
  int v1_n;

  multipack_assembler #(.COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rec(in_rec), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_active(out_active), .out_count(out_count), .state_dbg(state_dbg)
  );

  multipack_assembler #(.COUNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_rec(in_rec1), .in_last(in_last1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_word(out_word1),
    .out_active(out_active1), .out_count(out_count1), .state_dbg(state_dbg1)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors: compare every consumed word against the queue head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb4_unexpected: got word=%h active=%b count=%0d, required no word", out_word, out_active, out_count);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if ({out_word, out_active, out_count} !== e) begin
          errors++;
          $display("FAIL sb4_word: got word=%h active=%b count=%0d, required word=%h active=%b count=%0d",
                   out_word, out_active, out_count, e[18:7], e[6:3], e[2:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1) begin
      if (v1_n < 2) v1_t[v1_n] = cyc;
      v1_n++;
      checks++;
      if (exp1_q.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected: got word=%b, required no word", out_word1);
      end else begin
        logic [4:0] e;
        e = exp1_q.pop_front();
        if ({out_word1, out_active1, out_count1} !== e) begin
          errors++;
          $display("FAIL sb1_word: got word=%b active=%b count=%0d, required word=%b active=%b count=%0d",
                   out_word1, out_active1, out_count1, e[4:2], e[1], e[0]);
        end
      end
    end
  end

  // Reference packer for the COUNT=4 instance
  task automatic model_clear();
    m_word = '0;
    m_act  = '0;
    m_cnt  = 0;
  endtask

  task automatic model_accept(input logic [2:0] r, input logic l);
    m_word[3*m_cnt +: 3] = r;
    m_act[m_cnt]         = |r[1:0];
    m_cnt++;
    if (m_cnt == 4 || l) begin
      last_exp = {m_word, m_act, 3'(m_cnt)};
      exp_q.push_back(last_exp);
      model_clear();
    end
  endtask

  // Drivers: hold the record until an edge sees in_ready high
  task automatic send(input logic [2:0] r, input logic l);
    logic acc;
    int   n;
    in_valid = 1'b1; in_rec = r; in_last = l;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_rec   = 3'($urandom_range(0, 7));
    in_last  = 1'($urandom_range(0, 1));
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send4_timeout: got in_ready=0 for %0d cycles, required 1", n);
    end else begin
      model_accept(r, l);
    end
  endtask

  task automatic send1(input logic [2:0] r);
    logic acc;
    int   n;
    in_valid1 = 1'b1; in_rec1 = r; in_last1 = 1'b0;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready1;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid1 = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send1_timeout: got in_ready=0 for %0d cycles, required 1", n);
    end else begin
      exp1_q.push_back({r, |r[1:0], 1'b1});
    end
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      in_rec  = 3'($urandom_range(0, 7));
      in_last = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_word, out_active, out_count, state_dbg} !== {1'b1, 1'b0, 12'h0, 4'h0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset4: got rdy=%b vld=%b word=%h act=%b cnt=%0d st=%b, required rdy=1 vld=0 word=000 act=0000 cnt=0 st=0",
               in_ready, out_valid, out_word, out_active, out_count, state_dbg);
    end
    checks++;
    if ({in_ready1, out_valid1, out_word1, out_active1, out_count1} !== {1'b1, 1'b0, 3'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset1: got rdy=%b vld=%b word=%b act=%b cnt=%0d, required rdy=1 vld=0 word=000 act=0 cnt=0",
               in_ready1, out_valid1, out_word1, out_active1, out_count1);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_word();
    send(3'b101, 1'b0);
    send(3'b010, 1'b0);
    send(3'b100, 1'b0);
    send(3'b011, 1'b0);
    @(negedge clk);
    checks++;
    if ({out_valid, out_word, out_active, out_count} !== {1'b1, 12'h715, 4'b1011, 3'd4}) begin
      errors++;
      $display("FAIL full_word: got vld=%b word=%h act=%b cnt=%0d, required vld=1 word=715 act=1011 cnt=4",
               out_valid, out_word, out_active, out_count);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_word_pulse: got out_valid=%b one cycle later, required 0", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_partial_word();
    send(3'b111, 1'b0);
    send(3'b001, 1'b1);
    @(negedge clk);
    checks++;
    if ({out_valid, out_word, out_active, out_count} !== {1'b1, 12'h00F, 4'b0011, 3'd2}) begin
      errors++;
      $display("FAIL partial_word: got vld=%b word=%h act=%b cnt=%0d, required vld=1 word=00f act=0011 cnt=2",
               out_valid, out_word, out_active, out_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [2:0] r;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'($urandom_range(0, 7)), 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_rec  = 3'($urandom_range(0, 7));
      in_last = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_word, out_active, out_count} !== {1'b0, 1'b1, last_exp}) begin
        errors++;
        $display("FAIL backpressure_hold%0d: got rdy=%b vld=%b word=%h act=%b cnt=%0d, required rdy=0 vld=1 word=%h act=%b cnt=%0d",
                 i, in_ready, out_valid, out_word, out_active, out_count, last_exp[18:7], last_exp[6:3], last_exp[2:0]);
      end
      @(posedge clk);
      #1;
    end
    r = 3'($urandom_range(1, 7));
    out_ready = 1'b1;
    send(r, 1'b1);
    @(negedge clk);
    checks++;
    if ({out_word, out_count} !== {9'b0, r, 3'd1}) begin
      errors++;
      $display("FAIL backpressure_lane0: got word=%h cnt=%0d, required word=%h cnt=1", out_word, out_count, {9'b0, r});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    send(3'b110, 1'b0);
    send(3'b011, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_word, out_active, out_count, state_dbg} !== {1'b1, 1'b0, 12'h0, 4'h0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b vld=%b word=%h act=%b cnt=%0d st=%b, required rdy=1 vld=0 word=000 act=0000 cnt=0 st=0",
               in_ready, out_valid, out_word, out_active, out_count, state_dbg);
    end
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(3'b001, 1'b0);
    @(negedge clk);
    checks++;
    if ({out_valid, out_word, out_active, out_count} !== {1'b1, 12'h249, 4'b1111, 3'd4}) begin
      errors++;
      $display("FAIL reset_mid_word: got vld=%b word=%h act=%b cnt=%0d, required vld=1 word=249 act=1111 cnt=4",
               out_valid, out_word, out_active, out_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_bubbles();
    for (int w = 0; w < 6; w++) begin
      for (int l = 0; l < 4; l++) begin
        idle($urandom_range(0, 3));
        send(3'($urandom_range(0, 7)), (l < 3) && ($urandom_range(0, 3) == 0));
        if (m_cnt == 0) break;
      end
    end
    idle(3);
  endtask

  task automatic test_count1();
    v1_n = 0;
    send1(3'b100);
    send1(3'b010);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (v1_n !== 2) begin
      errors++;
      $display("FAIL count1_words: got %0d words, required 2", v1_n);
    end else begin
      checks++;
      if (v1_t[1] - v1_t[0] !== 2) begin
        errors++;
        $display("FAIL count1_spacing: got %0d cycles apart, required 2", v1_t[1] - v1_t[0]);
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; v1_n = 0;
    in_valid = 1'b0; in_rec = 3'b0; in_last = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_rec1 = 3'b0; in_last1 = 1'b0; out_ready1 = 1'b1;
    last_exp = '0;
    model_clear();

    test_reset();
    test_full_word();
    test_partial_word();
    test_backpressure();
    test_reset_mid();
    test_bubbles();
    test_count1();

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d/%0d words outstanding, required 0/0", exp_q.size(), exp1_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multipack_assembler.md
# multipack_assembler

Write-side counterpart of the packed-union lane reader. It accepts one 3-bit record (fields a, b, c) per handshake and packs consecutive records into a COUNT-lane packed union array word. Each lane holds a 3-bit raw view whose fields are a=bit 2, b=bit 1, c=bit 0. The completed word, a per-lane "active" mask and a fill count are presented downstream through a valid/ready handshake. The block sits between a record producer and any consumer that reads `union_t [COUNT-1:0]` words.

## Interface
- COUNT, 4, number of lanes per output word; legal range ≥ 1
- CW (localparam), $clog2(COUNT+1), width of out_count
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low; sampled on clk
- in_valid  input  1  record present
- in_ready  output  1  block can accept a record this cycle
- in_rec  input  3  record raw bits {a,b,c}
- in_last  input  1  qualifies the accepted record as the final one of a partial word
- out_valid  output  1  packed word available
- out_ready  input  1  consumer accepts word
- out_word  output  3*COUNT  packed union array; lane i occupies bits [3i+2:3i]
- out_active  output  COUNT  bit i = (lane i raw & 3'b011) != 0, for filled lanes only
- out_count  output  CW  number of lanes filled in out_word (1..COUNT)

## Operation
- Two states: FILL and HOLD. Reset state is FILL with lane index 0 and all registers cleared.
- FILL:
  - in_ready=1 and out_valid=0.
  - On in_valid, the record is written to lane[idx] and idx increments.
  - If idx==COUNT-1 or in_last=1, the block moves to HOLD and latches out_count=idx+1.
- Lanes not written in the current word read as 3'b000, and their active bit is 0.
- out_active is computed from the registered lanes, equivalent to per-lane (raw & 3'b011) != 0 masked by "filled". It may be a registered or a combinational decode of the stored word; it must be valid whenever out_valid=1.
- HOLD:
  - in_ready=0 and out_valid=1.
  - out_word, out_active and out_count stay stable until out_ready=1.
  - On out_valid && out_ready, the block moves to FILL, clears idx to 0 and zeroes all lanes.
- in_last on the record that fills lane COUNT-1 is redundant; the word is identical either way.
- in_last is ignored unless in_valid && in_ready.
- in_rec and in_last are don't-care when in_valid=0.
- With COUNT=1, every accepted record forms a complete word.

## Timing
- Reset values (rst_n=0 at a clk edge): in_ready=1, out_valid=0, out_word=0, out_active=0, out_count=0, state=FILL, idx=0.
- Reset mid-fill or mid-hold discards the partial or held word with no output.
- Latency: out_valid rises on the cycle after the edge that accepts the last record of a word.
- Throughput: one word per (lanes+1) cycles when out_ready is held high. There is no overlap; in_ready is 0 for the whole of HOLD, including the cycle in which the word is consumed.
- Outputs are registered except in_ready/out_valid, which decode state directly. Neither depends combinationally on in_valid or out_ready.
- idx width is $clog2(COUNT), minimum 1; idx never exceeds COUNT-1.

## Test plan
- Full word, COUNT=4:
  - Stimulus: records 3'b101, 3'b010, 3'b100, 3'b011 with out_ready=1.
  - Response: out_word=12'h715, out_active=4'b1011, out_count=4, out_valid high for exactly 1 cycle, 1 cycle after the 4th accept.
- Partial word via in_last, COUNT=4:
  - Stimulus: records 3'b111, then 3'b001 with in_last=1.
  - Response: out_word=12'h00F, out_active=4'b0011, out_count=2, upper lanes zero.
- Backpressure:
  - Stimulus: complete a word, then hold out_ready=0 for 5 cycles while in_valid=1 with varying in_rec.
  - Response: out_word/out_active/out_count are stable and in_ready=0 throughout, and no record is accepted. After out_ready=1, the next record lands in lane 0.
- Reset mid-operation:
  - Stimulus: accept 2 records, assert rst_n=0 for 1 cycle, then send 4 records 3'b001.
  - Response: all reset values hold after the reset edge, and the next word is 12'h249 with out_active=4'b1111 and no trace of the pre-reset records.
- Bubbles and don't-care inputs:
  - Stimulus: insert in_valid=0 cycles between records and toggle in_last on idle cycles.
  - Response: the word is unaffected and idle cycles do not advance idx.
- COUNT=1 instance:
  - Stimulus: records 3'b100 then 3'b010 back-to-back.
  - Response: two words, out_word=3'b100 with out_active=0, then out_word=3'b010 with out_active=1. Each has out_count=1 and arrives 2 cycles apart.
